// File: rtl/acc_pkg.sv
// Shared accelerator types and sizing constants.
// DATA_W / LANES size one adder-tree input group; group_t is the packed
// 16-lane vector presented to the adder tree (lane i at [i*DATA_W +: DATA_W]).
package acc_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned LANES  = 16;
   localparam int unsigned IDX_W  = $clog2(LANES);
   localparam int unsigned CNT_W  = IDX_W + 1;

   typedef logic [DATA_W-1:0] lane_t;
   typedef lane_t [LANES-1:0] group_t;

endpackage

// File: rtl/operand_loader_16_if.sv
// Stream bundle of the operand loader.
//   in_valid/in_ready/in_data/in_last : word stream from the producer
//   out_valid/out_ready/out_data/out_count : packed group stream to the adder tree
// slave  : loader view (consumes words, produces groups)
// master : environment view (produces words, consumes groups)
interface operand_loader_16_if #(
   parameter int unsigned DATA_W = acc_pkg::DATA_W,
   parameter int unsigned LANES  = acc_pkg::LANES
);
   localparam int unsigned CNT_W = $clog2(LANES) + 1;

   logic                    in_valid;
   logic                    in_ready;
   logic [DATA_W-1:0]       in_data;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic [LANES*DATA_W-1:0] out_data;
   logic [CNT_W-1:0]        out_count;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count
   );

endinterface

// File: rtl/lane_bank.sv
// One bank of LANES word registers plus the lane count of the group it holds.
//   clk, rst_n    : clock, async active-low reset (clears count only)
//   wr_en/wr_idx/wr_data : write one word into lane wr_idx
//   close/close_count    : latch the number of written lanes of the group
//   show          : bank is full and selected for reading
//   count         : lane count when shown, else 0
//   out_data      : packed lanes, lanes >= count forced to 0, all 0 when not shown
module lane_bank #(
   parameter int unsigned DATA_W = acc_pkg::DATA_W,
   parameter int unsigned LANES  = acc_pkg::LANES,
   localparam int unsigned IDX_W = $clog2(LANES),
   localparam int unsigned CNT_W = IDX_W + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    close,
   input  logic [CNT_W-1:0]        close_count,
   input  logic                    show,
   output logic [CNT_W-1:0]        count,
   output logic [LANES*DATA_W-1:0] out_data
);

   logic [DATA_W-1:0] mem [LANES];
   logic [CNT_W-1:0]  count_q;

   // Word storage needs no reset: the output mask hides anything not yet
   // written for the current group.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (close) begin
         count_q <= close_count;
      end
   end

   always_comb begin
      out_data = '0;
      for (int i = 0; i < LANES; i++) begin
         if (show && (CNT_W'(i) < count_q)) begin
            out_data[i*DATA_W +: DATA_W] = mem[i];
         end
      end
   end

   assign count = show ? count_q : '0;

endmodule

// File: rtl/operand_loader_16.sv
// Serial-to-parallel operand loader for the 16-input adder tree.
// Packs one word per cycle into ping-pong lane banks and presents each
// completed (or in_last-closed, zero-padded) group as one parallel vector.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of operand_loader_16_if (word in, group out)
module operand_loader_16 #(
   parameter int unsigned DATA_W = acc_pkg::DATA_W,
   parameter int unsigned LANES  = acc_pkg::LANES
) (
   input  logic                clk,
   input  logic                rst_n,
   operand_loader_16_if.slave  bus
);

   localparam int unsigned IDX_W = $clog2(LANES);
   localparam int unsigned CNT_W = IDX_W + 1;

   logic [1:0]       full_q, full_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;

   logic             accept;
   logic             close;
   logic             take;
   logic [CNT_W-1:0] close_count;

   logic [LANES*DATA_W-1:0] bank_data  [2];
   logic [CNT_W-1:0]        bank_count [2];

   // Ready depends on registered state only, so a release never ripples
   // combinationally into in_ready.
   assign bus.in_ready = !full_q[wr_bank_q];
   assign accept       = bus.in_valid && bus.in_ready;
   assign close        = accept && ((wr_idx_q == IDX_W'(LANES - 1)) || bus.in_last);
   assign take         = full_q[rd_bank_q] && bus.out_ready;
   assign close_count  = CNT_W'(wr_idx_q) + CNT_W'(1);

   // Close and take never hit the same bank: close needs the write bank
   // empty, take needs the read bank full.
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_idx_d  = wr_idx_q;
      if (accept) begin
         wr_idx_d = close ? '0 : wr_idx_q + IDX_W'(1);
      end
      if (close) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = ~wr_bank_q;
      end
      if (take) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_idx_q  <= '0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_idx_q  <= wr_idx_d;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      lane_bank #(
         .DATA_W (DATA_W),
         .LANES  (LANES)
      ) u_bank (
         .clk         (clk),
         .rst_n       (rst_n),
         .wr_en       (accept && (wr_bank_q == 1'(b))),
         .wr_idx      (wr_idx_q),
         .wr_data     (bus.in_data),
         .close       (close && (wr_bank_q == 1'(b))),
         .close_count (close_count),
         .show        (full_q[b] && (rd_bank_q == 1'(b))),
         .count       (bank_count[b]),
         .out_data    (bank_data[b])
      );
   end

   // Only the shown bank drives non-zero values, so OR acts as the read mux.
   assign bus.out_valid = full_q[rd_bank_q];
   assign bus.out_count = bank_count[0] | bank_count[1];
   assign bus.out_data  = bank_data[0] | bank_data[1];

endmodule

// File: tb/tb_operand_loader_16.sv
// Self-checking bench for operand_loader_16: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue-of-groups reference model.
module tb_operand_loader_16;
   import acc_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   operand_loader_16_if ifc ();

   operand_loader_16 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: complete groups waiting in order, plus the group being filled.
   typedef struct {
      group_t data;
      int     cnt;
   } grp_t;

   grp_t   q[$];
   group_t part = '0;
   int     pidx = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         part = '0;
         pidx = 0;
      end else begin
         automatic bit rdy = (q.size() < 2);
         automatic bit rel = (q.size() > 0) && ifc.out_ready;
         automatic bit acc = ifc.in_valid && rdy;
         if (rel) void'(q.pop_front());
         if (acc) begin
            part[pidx] = ifc.in_data;
            pidx++;
            if (pidx == LANES || ifc.in_last) begin
               q.push_back('{data: part, cnt: pidx});
               part = '0;
               pidx = 0;
            end
         end
      end
   end

   // Compare process: DUT outputs against the model on every falling edge.
   always @(negedge clk) begin
      automatic bit     v = (q.size() > 0);
      automatic group_t d = v ? q[0].data : '0;
      automatic int     c = v ? q[0].cnt : 0;
      check("in_ready", 512'(ifc.in_ready), 512'(q.size() < 2));
      check("out_valid", 512'(ifc.out_valid), 512'(v));
      check("out_count", 512'(ifc.out_count), 512'(c));
      check("out_data", ifc.out_data, d);
   end

   function automatic logic [31:0] lane(input int i);
      return ifc.out_data[i*32 +: 32];
   endfunction

   // Offer one word and hold it until accepted (bounded).
   task automatic put(input logic [31:0] d, input logic l);
      logic r;
      int   t = 0;
      ifc.in_valid = 1'b1;
      ifc.in_data  = d;
      ifc.in_last  = l;
      forever begin
         r = ifc.in_ready;
         @(negedge clk);
         #1;
         if (r) break;
         t++;
         if (t > 200) begin
            check("put_timeout", 512'(0), 512'(1));
            break;
         end
      end
      ifc.in_valid = 1'b0;
      ifc.in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      ifc.in_valid = 1'b0;
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic drain();
      ifc.out_ready = 1'b1;
      idle(4);
   endtask

   initial begin
      logic r;
      logic hold;
      int   nxt;
      int   acc_cnt;

      ifc.in_valid  = 1'b0;
      ifc.in_data   = '0;
      ifc.in_last   = 1'b0;
      ifc.out_ready = 1'b0;
      @(negedge clk);
      #1;
      check("rst_out_valid", 512'(ifc.out_valid), 512'(0));
      check("rst_out_count", 512'(ifc.out_count), 512'(0));
      check("rst_out_data", ifc.out_data, 512'(0));
      check("rst_in_ready", 512'(ifc.in_ready), 512'(1));
      rst_n = 1'b1;
      idle(2);

      // Streaming full group
      ifc.out_ready = 1'b1;
      for (int i = 1; i <= 16; i++) put(32'(i), 1'b0);
      check("stream_valid", 512'(ifc.out_valid), 512'(1));
      check("stream_count", 512'(ifc.out_count), 512'(16));
      check("stream_lane0", 512'(lane(0)), 512'(1));
      check("stream_lane15", 512'(lane(15)), 512'(32'h10));
      drain();

      // Partial group closed by in_last
      put(32'h9, 1'b0);
      put(32'ha, 1'b0);
      put(32'hb, 1'b1);
      check("part_count", 512'(ifc.out_count), 512'(3));
      check("part_lane2", 512'(lane(2)), 512'(32'hb));
      check("part_lane3", 512'(lane(3)), 512'(0));
      drain();

      // Back-pressure: 40 words offered, 32 accepted
      ifc.out_ready = 1'b0;
      nxt = 1;
      acc_cnt = 0;
      repeat (40) begin
         ifc.in_valid = 1'b1;
         ifc.in_data  = 32'(nxt);
         ifc.in_last  = 1'b0;
         r = ifc.in_ready;
         @(negedge clk);
         #1;
         if (r) begin
            acc_cnt++;
            nxt++;
         end
      end
      ifc.in_valid = 1'b0;
      check("bp_accepted", 512'(acc_cnt), 512'(32));
      check("bp_in_ready", 512'(ifc.in_ready), 512'(0));
      check("bp_lane0", 512'(lane(0)), 512'(1));
      check("bp_lane15", 512'(lane(15)), 512'(16));
      ifc.out_ready = 1'b1;
      @(negedge clk);
      #1;
      ifc.out_ready = 1'b0;
      check("bp_ready_after", 512'(ifc.in_ready), 512'(1));
      check("bp_second_lane0", 512'(lane(0)), 512'(17));
      drain();

      // Close of B on the same edge A is taken
      ifc.out_ready = 1'b0;
      for (int i = 1; i <= 16; i++) put(32'(100 + i), 1'b0);
      for (int i = 1; i <= 15; i++) put(32'(200 + i), 1'b0);
      ifc.out_ready = 1'b1;
      put(32'(216), 1'b0);
      check("sim_valid", 512'(ifc.out_valid), 512'(1));
      check("sim_b_lane0", 512'(lane(0)), 512'(201));
      check("sim_b_lane15", 512'(lane(15)), 512'(216));
      drain();

      // Reset with one full bank and 7 words pending
      ifc.out_ready = 1'b0;
      for (int i = 0; i < 23; i++) put(32'(32'h500 + i), 1'b0);
      rst_n = 1'b0;
      #2;
      check("mid_rst_valid", 512'(ifc.out_valid), 512'(0));
      check("mid_rst_count", 512'(ifc.out_count), 512'(0));
      check("mid_rst_data", ifc.out_data, 512'(0));
      check("mid_rst_ready", 512'(ifc.in_ready), 512'(1));
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      ifc.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) put(32'(32'h300 + i), 1'b0);
      check("post_rst_lane0", 512'(lane(0)), 512'(32'h300));
      check("post_rst_lane15", 512'(lane(15)), 512'(32'h30f));
      drain();

      // in_last on the 16th word, then a single-word group
      for (int i = 0; i < 15; i++) put(32'(32'h700 + i), 1'b0);
      put(32'h70f, 1'b1);
      check("last16_count", 512'(ifc.out_count), 512'(16));
      put(32'h55, 1'b1);
      check("single_count", 512'(ifc.out_count), 512'(1));
      check("single_lane0", 512'(lane(0)), 512'(32'h55));
      check("single_lane1", 512'(lane(1)), 512'(0));
      drain();

      // Randomized traffic; producer holds its word while not accepted
      hold = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (!hold) begin
            ifc.in_valid = ($urandom_range(0, 3) != 0);
            ifc.in_data  = $urandom;
            ifc.in_last  = ($urandom_range(0, 7) == 0);
         end
         ifc.out_ready = (n % 600 < 300) ? ($urandom_range(0, 3) != 0)
                                         : ($urandom_range(0, 3) == 0);
         r = ifc.in_ready;
         @(negedge clk);
         #1;
         hold = ifc.in_valid && !r;
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/operand_loader_16.md
# operand_loader_16

Serial-to-parallel operand loader that drives the 16-lane, 32-bit input side of the accelerator's 16-input adder tree. It accepts one 32-bit word per cycle over a valid/ready stream and packs words into 16-lane groups in two ping-pong banks. It presents each completed group as one parallel vector with its own valid/ready handshake. Short groups, closed early by `in_last`, are zero-padded so the tree sum is unaffected.

## Interface
Parameters:
- `DATA_W`, 32: lane width in bits.
- `LANES`, 16: lanes per group; must be a power of two.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a word this cycle.
- `in_data`  in  `DATA_W`  operand word.
- `in_last`  in  1  the word is the final one of its group (closes the group early).
- `out_valid`  out  1  `out_data` holds a complete group.
- `out_ready`  in  1  the consumer takes the group this cycle.
- `out_data`  out  `LANES*DATA_W`  lane i is at `[i*DATA_W +: DATA_W]`.
- `out_count`  out  `$clog2(LANES)+1`  number of written lanes in the presented group (1..16).

## Operation
- **State.** Two banks of `LANES` words each. Per bank: `full` flag and `count`. Global: `wr_bank`, `rd_bank` (1 bit each) and `wr_idx` (`$clog2(LANES)` bits).
- **Input handshake.**
  - `in_ready = !full[wr_bank]`, a combinational function of registered state only.
  - A word is accepted when `in_valid && in_ready`.
- **On accept:**
  - `bank[wr_bank][wr_idx] <= in_data`.
  - If `wr_idx == LANES-1` or `in_last`, the group closes: `full[wr_bank] <= 1`, `count[wr_bank] <= wr_idx+1`, `wr_idx <= 0`, `wr_bank` toggles.
  - Otherwise `wr_idx` increments.
- **Output.**
  - `out_valid = full[rd_bank]`.
  - `out_count = full[rd_bank] ? count[rd_bank] : 0`.
  - `out_data` lane i equals `bank[rd_bank][i]` when `i < out_count`, otherwise 0. Masking is applied on the output, so stale words are never visible.
- **On `out_valid && out_ready`:** `full[rd_bank] <= 0` and `rd_bank` toggles.
- **Simultaneous events.**
  - Closing the write bank and releasing the read bank in the same cycle is legal; both updates apply.
  - If a release frees the current write bank, `in_ready` rises the following cycle. There is no combinational ready-to-ready path.
- **Both banks full.** `in_ready = 0` and `in_data` is ignored. `in_last` on a rejected cycle has no effect.
- **`in_valid` low.** No state changes on the input side.
- **AXI-stream rules.** `out_data` and `out_count` stay stable while `out_valid && !out_ready`. The producer must hold `in_data` and `in_last` while `in_valid && !in_ready`.

## Timing
- **Reset values:** `out_valid = 0`, `out_count = 0`, `out_data = 0`, `in_ready = 1`, `wr_idx = 0`, `wr_bank = rd_bank = 0`. Reset mid-group discards both partial and full banks.
- **Latency:** the word that closes a group is accepted at edge N; `out_valid` is high in the cycle after edge N.
- **Throughput:** one word per cycle sustained, provided each group is drained within 16 cycles of being presented. A full 16-word group occupies the input for 16 cycles.
- **Wrap-around:** `wr_idx` reaching `LANES-1` returns to 0. `in_last` on lane 15 is equivalent to a natural close (count 16, not 17).
- **Single-word group:** `in_last` with `wr_idx = 0` gives `out_count = 1`; lanes 1..15 read 0.

## Structure
- **Shared package `acc_pkg`:**
  - Constants `DATA_W`, `LANES`, `IDX_W = $clog2(LANES)`, `CNT_W = IDX_W+1`.
  - Typedef `lane_t` (`DATA_W` bits).
  - Typedef `group_t` (`LANES` × `lane_t`, packed), shared with the adder tree input side.
- **Sub-module `lane_bank`:** one bank of `LANES` registers with write enable, write index, `count` register and masked packed output. It is instantiated twice. The top holds the pointers, full flags and handshake logic.

## Test plan
- **Streaming:** 16 words 1..16 with `out_ready = 1` → one group, `out_count = 16`, lane i = i+1 (lane 0 = 1, lane 15 = 0x10), `out_valid` one cycle after the 16th accept.
- **Partial group:** words 9, 0xa, 0xb with `in_last` on 0xb → `out_count = 3`, lanes 0..2 = 9, 0xa, 0xb, lanes 3..15 = 0.
- **Back-pressure:** `out_ready = 0` and 40 words offered → exactly 32 accepted, then `in_ready = 0`. Raise `out_ready` for one cycle → `in_ready = 1` the next cycle; the first group is words 1..16 in order.
- **Simultaneous close and release:** group B closes on the same edge group A is taken → no lost or duplicated group; B is presented the next cycle.
- **Reset mid-operation:** assert `rst_n = 0` after 7 words plus one full bank → all outputs take reset values. A following 16-word group appears with no stale lanes.
- **`in_last` on the 16th word:** `out_count = 16`; the next group starts at lane 0.
